tm_buffer_drain: RTL and testbench

//  Read-side drain engine for the Tm per-output-channel result buffers filled by the data path.
//  On start it streams pixel addresses 0..pixel_count-1 out of all Tm buffers in parallel.

---
 rtl/tm_buffer_drain.sv | 166 ++++++++++++++++
 tb/tb_tm_buffer_drain.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_buffer_drain.sv
// Drains the Tm per-channel result buffers in address order, applies optional ReLU per lane,
// and hands each packed word to feature-memory write-back over a backpressured valid/ready port.
//
// state  | meaning
// S_IDLE | waiting for start; count/relu are latched here
// S_RUN  | issuing buffer reads and streaming words out
// S_DONE | single-cycle completion pulse, then back to idle
module tm_buffer_drain #(
   parameter int TM            = 16,
   parameter int FEATURE_WIDTH = 8,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic [ADDR_WIDTH:0]           pixel_count_i,
   input  logic                          relu_en_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          buf_rd_en_o,
   output logic [ADDR_WIDTH-1:0]         buf_rd_addr_o,
   input  logic [TM*FEATURE_WIDTH-1:0]   buf_rd_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [TM*FEATURE_WIDTH-1:0]   out_data_o,
   output logic [ADDR_WIDTH-1:0]         out_addr_o,
   output logic                          out_last_o
);

   localparam int DW = TM * FEATURE_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  relu_q, relu_d;
   logic [ADDR_WIDTH:0]   issued_q, issued_d;
   logic [ADDR_WIDTH:0]   sent_q, sent_d;
   logic                  inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

   logic [DW-1:0]         fifo_data_q [2];
   logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;

   logic                  rd_en;
   logic                  push;
   logic                  pop;
   logic [1:0]            occupancy;
   logic [DW-1:0]         relu_data;

   assign push = inflight_q;
   assign pop  = out_valid_o & out_ready_i;

   // A word leaving this cycle frees its slot, so it does not count against the next read.
   assign occupancy = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      relu_d   = relu_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      busy_o   = 1'b0;
      done_o   = 1'b0;
      rd_en    = 1'b0;
      if (pop) begin
         sent_d = sent_q + ONE;
      end
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               count_d  = pixel_count_i;
               relu_d   = relu_en_i;
               issued_d = '0;
               sent_d   = '0;
               state_d  = (pixel_count_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            busy_o = 1'b1;
            rd_en  = (issued_q < count_q) && (occupancy < 2'd2);
            if (rd_en) begin
               issued_d = issued_q + ONE;
            end
            if (sent_d == count_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign inflight_d      = rd_en;
   assign inflight_addr_d = issued_q[ADDR_WIDTH-1:0];

   always_comb begin
      relu_data = buf_rd_data_i;
      for (int i = 0; i < TM; i++) begin
         if (relu_q && buf_rd_data_i[i*FEATURE_WIDTH + FEATURE_WIDTH-1]) begin
            relu_data[i*FEATURE_WIDTH +: FEATURE_WIDTH] = '0;
         end
      end
   end

   always_comb begin
      wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         count_q         <= '0;
         relu_q          <= 1'b0;
         issued_q        <= '0;
         sent_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_addr_q <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         fifo_cnt_q      <= '0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_addr_q[i] <= '0;
         end
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         relu_q          <= relu_d;
         issued_q        <= issued_d;
         sent_q          <= sent_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         fifo_cnt_q      <= fifo_cnt_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= relu_data;
            fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
         end
      end
   end

   assign buf_rd_en_o   = rd_en;
   assign buf_rd_addr_o = issued_q[ADDR_WIDTH-1:0];
   assign out_valid_o   = (fifo_cnt_q != 2'd0);
   assign out_data_o    = fifo_data_q[rd_ptr_q];
   assign out_addr_o    = fifo_addr_q[rd_ptr_q];
   assign out_last_o    = out_valid_o && ({1'b0, out_addr_o} == (count_q - ONE));

endmodule

// File: tb/tb_tm_buffer_drain.sv
// Bench for tm_buffer_drain: buffer RAM model, scoreboard of expected words,
// table of drain runs plus hand-written latency, empty, ReLU and reset-abort sequences.
module tb_tm_buffer_drain;

   localparam int TM = 16;
   localparam int FW = 8;
   localparam int AW = 10;
   localparam int DW = TM * FW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   pixel_count = '0;
   logic          relu_en = 1'b0;
   logic          busy, done, rd_en, out_valid, out_last;
   logic          out_ready = 1'b1;
   logic [AW-1:0] rd_addr, out_addr;
   logic [DW-1:0] rd_data = '0;
   logic [DW-1:0] out_data;

   always #5 clk = ~clk;

   tm_buffer_drain #(.TM(TM), .FEATURE_WIDTH(FW), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start),
      .pixel_count_i (pixel_count),
      .relu_en_i     (relu_en),
      .busy_o        (busy),
      .done_o        (done),
      .buf_rd_en_o   (rd_en),
      .buf_rd_addr_o (rd_addr),
      .buf_rd_data_i (rd_data),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_data_o    (out_data),
      .out_addr_o    (out_addr),
      .out_last_o    (out_last)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          last;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      int cnt;
      bit relu;
      int mode;
      int rpat;
      int exp_words;
      int exp_last;
   } vec_t;

   word_t sb_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    data_mode = 0;
   int    rpat = 0;
   int    phase = 0;
   int    t0 = 0;

   int            words, rd_cnt, val_cycles, busy_cycles, done_cnt, last_cnt;
   int            first_rd_cyc, first_val_cyc, done_cyc, issue_m, fifo_m, occ_m;
   bit            inflight_m, stall_hold, pop_m;
   logic [AW-1:0] last_addr, held_addr;
   logic [DW-1:0] held_data, first_data;
   word_t         mon_a, mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [FW-1:0] lane_val(int mode, int a, int i);
      int v;
      case (mode)
         0:       v = a * 16 + i;
         1:       v = (i % 2 == 0) ? -5 : 7;
         default: v = a * 37 + i * 11 + 3;
      endcase
      return 8'(v);
   endfunction

   function automatic logic [DW-1:0] raw_word(int mode, int a);
      logic [DW-1:0] w;
      for (int i = 0; i < TM; i++) w[i*FW +: FW] = lane_val(mode, a, i);
      return w;
   endfunction

   function automatic logic [DW-1:0] exp_word(int mode, bit relu, int a);
      logic [DW-1:0] w;
      logic [FW-1:0] l;
      for (int i = 0; i < TM; i++) begin
         l = lane_val(mode, a, i);
         w[i*FW +: FW] = (relu && l[FW-1]) ? '0 : l;
      end
      return w;
   endfunction

   // Buffer RAM: one-cycle read latency, garbage on cycles without a strobe.
   always @(posedge clk)
      rd_data <= rd_en ? raw_word(data_mode, int'(rd_addr)) : {$urandom, $urandom, $urandom, $urandom};

   always @(posedge clk) begin
      #1;
      case (rpat)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (phase == 0);
            phase = (phase + 1) % 3;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [139:0] act, input logic [139:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input int act, input int exp);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         fifo_m = 0;
         inflight_m = 0;
         stall_hold = 0;
         issue_m = 0;
      end else begin
         pop_m = out_valid && out_ready;
         check("valid_vs_model", 140'(out_valid), 140'(fifo_m != 0));
         if (rd_en) begin
            occ_m = fifo_m + int'(inflight_m) - int'(pop_m);
            check("issue_occupancy", 140'(occ_m < 2), 140'(1'b1));
            check("rd_addr", 140'(rd_addr), 140'(issue_m[AW-1:0]));
            if (rd_cnt == 0) first_rd_cyc = cyc;
            rd_cnt++;
            issue_m++;
         end
         if (out_valid) begin
            if (val_cycles == 0) begin
               first_val_cyc = cyc;
               first_data = out_data;
            end
            val_cycles++;
         end
         if (stall_hold)
            check("stall_hold", 140'({out_valid, out_addr, out_data}), 140'({1'b1, held_addr, held_data}));
         stall_hold = out_valid && !out_ready;
         held_addr = out_addr;
         held_data = out_data;
         if (pop_m) begin
            words++;
            mon_a.addr = out_addr;
            mon_a.last = out_last;
            mon_a.data = out_data;
            if (sb_q.size() == 0) begin
               fail("sb_extra_word", int'(out_addr), -1);
            end else begin
               mon_e = sb_q.pop_front();
               check("word", 140'(mon_a), 140'(mon_e));
            end
            if (out_last) begin
               last_cnt++;
               last_addr = out_addr;
            end
         end
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 140'(busy), 140'(1'b0));
         end
         fifo_m = fifo_m + int'(inflight_m) - int'(pop_m);
         inflight_m = rd_en;
      end
   end

   task automatic clear_stats();
      words = 0; rd_cnt = 0; val_cycles = 0; busy_cycles = 0; done_cnt = 0; last_cnt = 0;
      first_rd_cyc = -1; first_val_cyc = -1; done_cyc = -1; issue_m = 0;
      last_addr = '0;
   endtask

   task automatic launch(input int cnt, input bit relu, input int mode);
      word_t w;
      data_mode = mode;
      clear_stats();
      sb_q.delete();
      for (int a = 0; a < cnt; a++) begin
         w.addr = a[AW-1:0];
         w.last = (a == cnt - 1);
         w.data = exp_word(mode, relu, a);
         sb_q.push_back(w);
      end
      @(posedge clk);
      #1;
      start = 1'b1;
      pixel_count = cnt[AW:0];
      relu_en = relu;
      t0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      pixel_count = 11'($urandom_range(0, 2047));
      relu_en = ~relu;
   endtask

   task automatic wait_done(input int max_cycles);
      for (int k = 0; k < max_cycles && done_cnt == 0; k++) @(posedge clk);
      if (done_cnt == 0) fail("timeout_waiting_done", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic end_checks(input int exp_words, input int exp_last);
      check("done_count", 140'(done_cnt), 140'(1));
      check("word_count", 140'(words), 140'(exp_words));
      check("sb_leftover", 140'(sb_q.size()), 140'(0));
      check("rd_count", 140'(rd_cnt), 140'(exp_words));
      check("last_count", 140'(last_cnt), 140'(exp_words > 0 ? 1 : 0));
      if (exp_words > 0) check("last_addr", 140'(last_addr), 140'(exp_last[AW-1:0]));
      check("idle_after_done", 140'({busy, out_valid, rd_en}), 140'(0));
   endtask

   vec_t vecs [8];

   initial begin
      vecs[0] = '{cnt: 4,    relu: 0, mode: 0, rpat: 1, exp_words: 4,    exp_last: 3};
      vecs[1] = '{cnt: 5,    relu: 1, mode: 1, rpat: 0, exp_words: 5,    exp_last: 4};
      vecs[2] = '{cnt: 7,    relu: 1, mode: 2, rpat: 2, exp_words: 7,    exp_last: 6};
      vecs[3] = '{cnt: 1,    relu: 0, mode: 2, rpat: 1, exp_words: 1,    exp_last: 0};
      vecs[4] = '{cnt: 3,    relu: 0, mode: 2, rpat: 2, exp_words: 3,    exp_last: 2};
      vecs[5] = '{cnt: 16,   relu: 1, mode: 2, rpat: 1, exp_words: 16,   exp_last: 15};
      vecs[6] = '{cnt: 1024, relu: 0, mode: 2, rpat: 0, exp_words: 1024, exp_last: 1023};
      vecs[7] = '{cnt: 9,    relu: 0, mode: 0, rpat: 2, exp_words: 9,    exp_last: 8};

      clear_stats();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 140'({busy, done, rd_en, out_valid, out_last, out_addr, out_data}), 140'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Latency and busy window with a free-running consumer.
      rpat = 0;
      launch(4, 1'b0, 0);
      wait_done(60);
      check("lat_first_rd", 140'(first_rd_cyc - t0), 140'(1));
      check("lat_first_valid", 140'(first_val_cyc - t0), 140'(3));
      check("lat_done", 140'(done_cyc - t0), 140'(7));
      check("busy_cycles", 140'(busy_cycles), 140'(6));
      check("valid_cycles", 140'(val_cycles), 140'(4));
      end_checks(4, 3);

      for (int v = 0; v < 8; v++) begin
         rpat = vecs[v].rpat;
         launch(vecs[v].cnt, vecs[v].relu, vecs[v].mode);
         wait_done(vecs[v].cnt * 4 + 40);
         end_checks(vecs[v].exp_words, vecs[v].exp_last);
      end

      // ReLU on alternating -5/+7 lanes: even lanes clamp, odd lanes pass 7.
      rpat = 0;
      launch(2, 1'b1, 1);
      wait_done(40);
      check("relu_word", 140'(first_data), 140'({8{16'h0700}}));
      end_checks(2, 1);

      // Empty drain: done next cycle, nothing read or emitted.
      launch(0, 1'b0, 0);
      wait_done(20);
      check("empty_done_lat", 140'(done_cyc - t0), 140'(1));
      check("empty_rd", 140'(rd_cnt), 140'(0));
      check("empty_valid", 140'(val_cycles), 140'(0));
      check("empty_done_count", 140'(done_cnt), 140'(1));

      // Abort by reset mid-drain, with a start pulse during busy that must be ignored.
      launch(12, 1'b0, 2);
      for (int k = 0; k < 60 && words < 3; k++) @(posedge clk);
      if (words < 3) fail("timeout_waiting_3_words", words, 3);
      #1;
      start = 1'b1;
      pixel_count = 11'd2;
      relu_en = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("busy_after_extra_start", 140'(busy), 140'(1'b1));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs", 140'({busy, done, rd_en, out_valid, out_last, out_addr, out_data}), 140'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      sb_q.delete();
      repeat (3) @(negedge clk);
      check("abort_no_done", 140'(done_cnt), 140'(0));
      check("abort_idle", 140'({busy, out_valid, rd_en}), 140'(0));

      launch(2, 1'b0, 2);
      wait_done(40);
      end_checks(2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
